// File: rtl/wb_master_pkg.sv
// Shared types and bus widths for the user-area Wishbone LA master.
package wb_master_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  localparam int unsigned WB_ADR_W = 32;
  localparam int unsigned WB_DAT_W = 32;
  localparam int unsigned WB_SEL_W = 4;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Bus watchdog: counts BUS cycles without ack, flags the last permitted cycle.
module wb_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + TO_W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/wb_la_master.sv
// Wishbone classic single-cycle initiator driven by a valid/ready command port,
// with a timeout watchdog so a silent slave cannot hang the master.
module wb_la_master
  import wb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned TO_W           = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [WB_ADR_W-1:0] cmd_adr_i,
  input  logic [WB_DAT_W-1:0] cmd_dat_i,
  input  logic [WB_SEL_W-1:0] cmd_sel_i,
  output logic                rsp_valid_o,
  output logic [WB_DAT_W-1:0] rsp_dat_o,
  output logic                rsp_err_o,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [WB_SEL_W-1:0] wbm_sel_o,
  output logic [WB_ADR_W-1:0] wbm_adr_o,
  output logic [WB_DAT_W-1:0] wbm_dat_o,
  input  logic [WB_DAT_W-1:0] wbm_dat_i,
  input  logic                wbm_ack_i
);

  state_t state;
  logic   ctr_clr;
  logic   ctr_en;
  logic   expired;

  // Counter is parked at zero while idle so each transaction starts fresh.
  always_comb begin
    ctr_clr = (state == IDLE);
    ctr_en  = (state == BUS) && !wbm_ack_i;
  end

  wb_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_timeout (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .expired (expired)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      cmd_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_dat_o   <= '0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            wbm_we_o    <= cmd_we_i;
            wbm_adr_o   <= cmd_adr_i;
            wbm_dat_o   <= cmd_dat_i;
            wbm_sel_o   <= cmd_sel_i;
            wbm_cyc_o   <= 1'b1;
            wbm_stb_o   <= 1'b1;
            cmd_ready_o <= 1'b0;
            state       <= BUS;
          end
        end
        BUS: begin
          // Ack takes priority over a simultaneous timeout.
          if (wbm_ack_i) begin
            rsp_dat_o   <= wbm_we_o ? '0 : wbm_dat_i;
            rsp_err_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            state       <= RESP;
          end else if (expired) begin
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b1;
            rsp_valid_o <= 1'b1;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            state       <= RESP;
          end
        end
        RESP: begin
          rsp_valid_o <= 1'b0;
          cmd_ready_o <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          state       <= IDLE;
          cmd_ready_o <= 1'b1;
          rsp_valid_o <= 1'b0;
          wbm_cyc_o   <= 1'b0;
          wbm_stb_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_la_master.sv
// Scoreboard bench for wb_la_master: driver plays command source and slave,
// monitor pops expected responses whenever rsp_valid_o pulses.
module tb_wb_la_master;

  localparam int unsigned TO = 8;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [31:0] cmd_adr_i;
  logic [31:0] cmd_dat_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  wb_la_master #(
    .TIMEOUT_CYCLES (TO),
    .TO_W           (8)
  ) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_we_i    (cmd_we_i),
    .cmd_adr_i   (cmd_adr_i),
    .cmd_dat_i   (cmd_dat_i),
    .cmd_sel_i   (cmd_sel_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_dat_o   (rsp_dat_o),
    .rsp_err_o   (rsp_err_o),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_ack_i   (wbm_ack_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [31:0] dat;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   pulse_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_cnt  = 0;
  logic prev_valid = 1'b0;
  rsp_t mon_e;

  always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a transaction acks iff the slave answers within TO BUS cycles.
  function automatic rsp_t model(input logic we, input int ack_cyc, input logic [31:0] rdata);
    rsp_t r;
    r.err = !(ack_cyc >= 1 && ack_cyc <= int'(TO));
    r.dat = (r.err || we) ? 32'h0 : rdata;
    return r;
  endfunction

  always @(negedge wb_clk_i) begin
    if (rsp_valid_o) begin
      chk("rsp_width", {31'b0, prev_valid}, 32'h0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp_valid_o=1 expected no response at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_dat", rsp_dat_o, mon_e.dat);
        chk("rsp_err", {31'b0, rsp_err_o}, {31'b0, mon_e.err});
      end
      pulse_q.push_back(cyc_cnt);
    end
    prev_valid = rsp_valid_o;
  end

  task automatic wait_ready();
    int waited = 0;
    @(negedge wb_clk_i);
    while (!cmd_ready_o && waited < 50) begin
      @(negedge wb_clk_i);
      waited++;
    end
    if (!cmd_ready_o) chk("ready_timeout", {31'b0, cmd_ready_o}, 32'h1);
  endtask

  task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input int ack_cyc, input logic [31:0] rdata);
    rsp_t e;
    wait_ready();
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_dat_i   = dat;
    cmd_sel_i   = sel;
    e = model(we, ack_cyc, rdata);
    exp_q.push_back(e);
    @(posedge wb_clk_i);
    #1;
    cmd_valid_i = 1'b0;
    cmd_we_i    = ~we;
    cmd_adr_i   = $urandom;
    cmd_dat_i   = $urandom;
    cmd_sel_i   = 4'($urandom);
    for (int c = 1; c <= int'(TO); c++) begin
      @(negedge wb_clk_i);
      chk("bus_cyc_stb", {30'b0, wbm_cyc_o, wbm_stb_o}, 32'h3);
      chk("bus_adr", wbm_adr_o, adr);
      chk("bus_dat", wbm_dat_o, dat);
      chk("bus_we_sel", {27'b0, wbm_we_o, wbm_sel_o}, {27'b0, we, sel});
      chk("bus_ready", {31'b0, cmd_ready_o}, 32'h0);
      chk("bus_no_rsp", {31'b0, rsp_valid_o}, 32'h0);
      if (c == ack_cyc) begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = rdata;
      end
      @(posedge wb_clk_i);
      #1;
      wbm_ack_i = 1'b0;
      wbm_dat_i = $urandom;
      if (c == ack_cyc) break;
    end
    @(negedge wb_clk_i);
    chk("resp_cyc", {31'b0, wbm_cyc_o}, 32'h0);
    chk("resp_ready", {31'b0, cmd_ready_o}, 32'h0);
    chk("resp_pulse", {31'b0, rsp_valid_o}, 32'h1);
    @(negedge wb_clk_i);
    chk("idle_ready", {31'b0, cmd_ready_o}, 32'h1);
    chk("idle_no_rsp", {31'b0, rsp_valid_o}, 32'h0);
    chk("rsp_dat_hold", rsp_dat_o, e.dat);
  endtask

  initial begin
    rsp_t e;
    int   n;
    int   drain;
    wb_rst_i    = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_we_i    = 1'b0;
    cmd_adr_i   = '0;
    cmd_dat_i   = '0;
    cmd_sel_i   = '0;
    wbm_dat_i   = '0;
    wbm_ack_i   = 1'b0;
    repeat (2) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    chk("reset_ready", {31'b0, cmd_ready_o}, 32'h1);
    chk("reset_rsp", {rsp_dat_o[29:0], rsp_valid_o, rsp_err_o}, 32'h0);
    chk("reset_bus_ctl", {25'b0, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}, 32'h0);
    chk("reset_bus_adr", wbm_adr_o, 32'h0);
    chk("reset_bus_dat", wbm_dat_o, 32'h0);

    // Directed cases
    txn(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 1, 32'hFFFF_FFFF);
    txn(1'b0, 32'h3000_0000, 32'h1111_2222, 4'hF, 4, 32'h0000_1234);
    txn(1'b0, 32'h3000_0008, 32'h0, 4'h3, 0, 32'hAAAA_AAAA);
    txn(1'b0, 32'h3000_000C, 32'h0, 4'hF, 8, 32'h0000_0055);

    // Reset during BUS cycle 2: the command must vanish without a response.
    wait_ready();
    cmd_valid_i = 1'b1;
    cmd_we_i    = 1'b0;
    cmd_adr_i   = 32'h3000_0010;
    cmd_sel_i   = 4'hF;
    @(posedge wb_clk_i);
    #1 cmd_valid_i = 1'b0;
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    chk("rst_mid_busy", {31'b0, wbm_cyc_o}, 32'h1);
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    chk("rst_mid_cyc_stb", {30'b0, wbm_cyc_o, wbm_stb_o}, 32'h0);
    chk("rst_mid_ready", {31'b0, cmd_ready_o}, 32'h1);
    chk("rst_mid_rsp", {31'b0, rsp_valid_o}, 32'h0);
    repeat (TO + 2) @(negedge wb_clk_i);
    chk("rst_mid_no_cyc", {31'b0, wbm_cyc_o}, 32'h0);

    // Back-to-back with cmd_valid_i held, zero-wait acks, then spurious acks.
    wait_ready();
    cmd_valid_i = 1'b1;
    cmd_we_i    = 1'b1;
    cmd_adr_i   = 32'h3000_0020;
    cmd_dat_i   = 32'h0BAD_F00D;
    cmd_sel_i   = 4'hC;
    e = model(1'b1, 1, 32'h0);
    exp_q.push_back(e);
    n = pulse_q.size();
    @(posedge wb_clk_i);
    #1;
    cmd_we_i  = 1'b0;
    cmd_adr_i = 32'h3000_0024;
    cmd_dat_i = 32'h0;
    cmd_sel_i = 4'hF;
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h1357_9BDF;
    e = model(1'b0, 1, 32'h1357_9BDF);
    exp_q.push_back(e);
    @(posedge wb_clk_i);
    #1 wbm_ack_i = 1'b0;
    @(posedge wb_clk_i);
    @(posedge wb_clk_i);
    #1;
    cmd_valid_i = 1'b0;
    wbm_ack_i   = 1'b1;
    @(negedge wb_clk_i);
    chk("b2b_second_adr", wbm_adr_o, 32'h3000_0024);
    @(posedge wb_clk_i);
    #1 wbm_ack_i = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    wbm_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge wb_clk_i);
      chk("spurious_ack_cyc", {31'b0, wbm_cyc_o}, 32'h0);
    end
    wbm_ack_i = 1'b0;
    chk("b2b_pulse_count", pulse_q.size() - n, 32'd2);
    if (pulse_q.size() - n == 2)
      chk("b2b_spacing", pulse_q[n+1] - pulse_q[n], 32'd3);

    // Randomized traffic; ack_cyc 0 or beyond TO means a silent slave.
    for (int i = 0; i < 40; i++) begin
      txn(1'($urandom), $urandom, $urandom, 4'($urandom),
          int'($urandom_range(0, TO + 2)), $urandom);
    end

    drain = 0;
    while (exp_q.size() != 0 && drain < 20) begin
      @(negedge wb_clk_i);
      drain++;
    end
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_la_master.md
Name: wb_la_master

Overview:
Wishbone classic (B4, non-pipelined) initiator living in the user area. It is the master end of the WB MI A slave interface that user-area peripherals expose. A simple valid/ready command port, normally driven from logic-analyzer probes or a small sequencer, launches single read or write cycles. Results come back on a one-cycle response strobe. A bus-timeout watchdog guarantees the master never hangs on a silent slave.

Parameters:
TIMEOUT_CYCLES, 255, maximum BUS-state cycles without ack before abort; legal range 1..2^TO_W-1.
TO_W, 8, width of the timeout counter.

Ports:
wb_clk_i  input  1  single clock; all logic on rising edge.
wb_rst_i  input  1  reset; synchronous, active-high.
cmd_valid_i  input  1  command present.
cmd_ready_o  output  1  master can accept a command.
cmd_we_i  input  1  1 = write, 0 = read.
cmd_adr_i  input  32  byte address.
cmd_dat_i  input  32  write data.
cmd_sel_i  input  4  byte lane selects.
rsp_valid_o  output  1  one-cycle pulse: transaction finished.
rsp_dat_o  output  32  read data; 0 for writes and on error.
rsp_err_o  output  1  qualified by rsp_valid_o; 1 = timeout abort.
wbm_cyc_o  output  1  WB cycle.
wbm_stb_o  output  1  WB strobe.
wbm_we_o  output  1  WB write enable.
wbm_sel_o  output  4  WB byte selects.
wbm_adr_o  output  32  WB address.
wbm_dat_o  output  32  WB write data.
wbm_dat_i  input  32  WB read data.
wbm_ack_i  input  1  WB acknowledge.

Behaviour:
- Reset (synchronous, wb_rst_i=1 at an edge): state=IDLE. Outputs go to: cmd_ready_o=1, rsp_valid_o=0, rsp_err_o=0, rsp_dat_o=0, wbm_cyc_o=0, wbm_stb_o=0, wbm_we_o=0, wbm_sel_o=0, wbm_adr_o=0, wbm_dat_o=0, timeout counter=0.
- All outputs are registered; there is no combinational path from any input to any output.
- FSM states are IDLE, BUS and RESP.
- IDLE:
  - cmd_ready_o=1.
  - When cmd_valid_i is high at an edge, latch we/adr/dat/sel onto the wbm_* outputs, set cyc=stb=1, clear the counter and go to BUS.
- BUS:
  - cmd_ready_o=0. cyc, stb, we, adr, sel and dat are held stable.
  - Counter increments every cycle without ack.
  - If wbm_ack_i=1: capture wbm_dat_i into rsp_dat_o for a read (0 for a write), set rsp_err_o=0, drop cyc/stb at the same edge, pulse rsp_valid_o, go to RESP.
  - Else if counter==TIMEOUT_CYCLES-1: drop cyc/stb, set rsp_dat_o=0 and rsp_err_o=1, pulse rsp_valid_o, go to RESP.
  - Ack and timeout in the same cycle: ack wins (normal completion).
- RESP:
  - rsp_valid_o is high for exactly this one cycle; there is no backpressure.
  - cmd_ready_o=0. Return to IDLE next edge.
  - rsp_dat_o and rsp_err_o hold their value until the next completion.
- Timing:
  - Command accepted at edge N → cyc/stb high from N.
  - Ack sampled at edge N+k → cyc/stb low and rsp_valid_o high after N+k.
  - With a zero-wait slave, cyc is high for 1 cycle, and the best-case rate is one transaction every 3 cycles.
- wbm_ack_i outside BUS (spurious ack) is ignored; no state change.
- cmd_valid_i while cmd_ready_o=0 is ignored and not queued. The source must hold it until ready.
- Reset mid-transaction: cyc/stb are low after the reset edge, no rsp_valid_o is issued, and the command is lost.
- wbm_dat_o keeps the latched cmd_dat_i even on reads; slaves ignore it when we=0.

Decomposition:
- Package wb_master_pkg:
  - state enum {IDLE, BUS, RESP};
  - WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4;
  - default TIMEOUT_CYCLES.
- One sub-module, wb_timeout_ctr: clear/enable inputs, TO_W-bit counter, expire flag at TIMEOUT_CYCLES-1.

Test Plan:
- Write, zero-wait: cmd we=1, adr=0x3000_0004, dat=0xDEAD_BEEF, sel=0xF; slave acks in the first cycle → cyc/stb high exactly 1 cycle with those values; rsp_valid_o 1 cycle later, rsp_err_o=0, rsp_dat_o=0.
- Read, 3 wait states: cmd we=0, adr=0x3000_0000; slave acks on the 4th BUS cycle with 0x0000_1234 → adr held 4 cycles; rsp_dat_o=0x0000_1234, rsp_err_o=0.
- Timeout: TIMEOUT_CYCLES=8, slave never acks → cyc drops after exactly 8 cycles; rsp_valid_o pulses with rsp_err_o=1, rsp_dat_o=0; cmd_ready_o=1 the cycle after.
- Ack on the expiry cycle: TIMEOUT_CYCLES=8, ack on BUS cycle 8 with data 0x55 → rsp_err_o=0, rsp_dat_o=0x55.
- Reset mid-BUS: assert wb_rst_i in BUS cycle 2 → cyc/stb=0 after that edge, no rsp_valid_o, cmd_ready_o=1.
- Back-to-back plus spurious ack: cmd_valid_i held high for two commands with zero-wait acks, and an extra ack in IDLE → exactly 2 rsp_valid_o pulses, 3 cycles apart; the extra ack causes no cyc assertion.
